// File: rtl/key_debouncer.sv
// Debounces WIDTH raw pins into clean levels plus one-cycle press/release pulses.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add hold-to-repeat pulses on key_press.
module key_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_debouncer: STABLE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  // Outputs carry no handshake: key_press/key_release are single-cycle strobes
  // qualified by nothing else, and key_state is a plain level.
  logic [WIDTH-1:0] sync1, sync2, sync;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] flip, press_evt, release_evt, repeat_evt;

  assign sync = sync2 ^ INACTIVE;

  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (sync[i] != key_state[i]) && (cnt[i] == CNT_MAX);
    end
    press_evt   = flip & sync;
    release_evt = flip & ~sync;
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int R_W  = $clog2(RMAX + 1);
  localparam logic [R_W-1:0] DLY_MAX = R_W'(REPEAT_DELAY - 1);
  localparam logic [R_W-1:0] PER_MAX = R_W'(REPEAT_PERIOD - 1);

  logic [R_W-1:0] rcnt [WIDTH];
  logic [WIDTH-1:0] repeating;

  // A release flip suppresses the repeat so press and release never coincide.
  always_comb begin
    repeat_evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      repeat_evt[i] = key_state[i] && !flip[i] &&
                      (repeating[i] ? (rcnt[i] == PER_MAX) : (rcnt[i] == DLY_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      repeating <= '0;
      for (int i = 0; i < WIDTH; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!key_state[i] || flip[i]) begin
          rcnt[i]      <= '0;
          repeating[i] <= 1'b0;
        end else if (repeat_evt[i]) begin
          rcnt[i]      <= '0;
          repeating[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + R_W'(1);
        end
      end
    end
  end
`else
  assign repeat_evt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= INACTIVE;
      sync2       <= INACTIVE;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1       <= raw_in;
      sync2       <= sync1;
      key_state   <= key_state ^ flip;
      key_press   <= press_evt | repeat_evt;
      key_release <= release_evt;
      // Any agreement clears the count, so only an unbroken mismatch run flips.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == key_state[i] || flip[i]) cnt[i] <= '0;
        else                                    cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized scoreboard bench for key_debouncer against a sliding-window model.
// The model mirrors the DUT's KEY_DEBOUNCER_AUTOREPEAT_EN setting.
module tb_key_debouncer;
  localparam int W  = 4;
  localparam int SC = 4;
  localparam int AL = 1;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HL = SC + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw_in = '1;
  logic [W-1:0] key_state, key_press, key_release;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   hist[$];
  logic [W-1:0]   m_state;
  int             hold[W];
  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;

  key_debouncer #(
    .WIDTH(W), .STABLE_CYCLES(SC), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Model: hist holds the pressed level seen at the pins on each past edge
  // (newest last). A channel flips when the STABLE samples that have crossed
  // the two-flop synchronizer all disagree with the debounced level.
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < HL; k++) hist.push_back('0);
    m_state = '0;
    for (int c = 0; c < W; c++) hold[c] = 0;
  endtask

  task automatic drive(input logic [W-1:0] raw, input logic r);
    logic [W-1:0] pr, rl, smp;
    bit all_diff;
    @(negedge clk);
    raw_in = raw;
    rst    = r;
    pr = '0;
    rl = '0;
    if (r) begin
      model_reset();
    end else begin
      hist.push_back((AL != 0) ? ~raw : raw);
      void'(hist.pop_front());
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < SC; k++) begin
          smp = hist[HL-3-k];
          if (smp[c] == m_state[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_state[c] = ~m_state[c];
          if (m_state[c]) begin
            pr[c]   = 1'b1;
            hold[c] = 0;
          end else begin
            rl[c] = 1'b1;
          end
        end else if (m_state[c]) begin
          hold[c]++;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
          if (hold[c] >= RD && ((hold[c] - RD) % RP) == 0) pr[c] = 1'b1;
`endif
        end
      end
    end
    exp_q.push_back({m_state, pr, rl});
  endtask

  task automatic hold_raw(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) drive(raw, 1'b0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [3*W-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {key_state, key_press, key_release};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cycle=%0d state/press/release got=%b_%b_%b want=%b_%b_%b",
                   cyc, a[3*W-1:2*W], a[2*W-1:W], a[W-1:0],
                   e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] r;
    int drain;
    model_reset();
    // reset, then idle with all keys released
    for (int k = 0; k < 3; k++) drive(4'b1111, 1'b1);
    hold_raw(4'b1111, 20);
    // channel 0 clean press
    hold_raw(4'b1110, 12);
    hold_raw(4'b1111, 10);
    // channel 1 glitch then real press
    hold_raw(4'b1101, 3);
    hold_raw(4'b1111, 1);
    hold_raw(4'b1101, 10);
    hold_raw(4'b1111, 10);
    // channels 2 and 3 together
    hold_raw(4'b0011, 10);
    hold_raw(4'b1111, 10);
    // reset interrupts a press count
    hold_raw(4'b1110, 2);
    drive(4'b1110, 1'b1);
    hold_raw(4'b1110, 10);
    hold_raw(4'b1111, 10);
    // long hold for auto-repeat
    hold_raw(4'b1110, 35);
    hold_raw(4'b1111, 12);
    // random toggling with occasional reset
    r = 4'b1111;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
      end
      drive(r, ($urandom_range(0, 199) == 0));
    end
    hold_raw(4'b1111, 12);
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
